// File: rtl/spi_sample_monitor.sv
// spi_sample_monitor: moving average, hysteresis alarm, error/fault and timeout
// supervision over the audited byte stream of the SPI receiver.
// Ports:
//   clk_in     system clock, all logic on posedge
//   rst        synchronous active-low reset
//   byte_valid one-cycle pulse, one frame ended
//   byte_ok    frame had exactly 8 bits (qualified by byte_valid)
//   byte_data  received byte (qualified by byte_valid && byte_ok)
//   avg_out    moving average of the last 2**AVG_LOG2 good samples
//   avg_valid  one-cycle pulse when avg_out updated from a full window
//   alarm      hysteresis threshold alarm
//   fault      high while in FAULT
//   timeout    no good frame for TIMEOUT_CYC cycles
//   err_cnt    total bad frames, saturating at 255
//   led        active-low LEDs: led[0]=~alarm, led[1]=~(fault|timeout)
module spi_sample_monitor #(
   parameter int         AVG_LOG2    = 2,
   parameter logic [7:0] THR_HI      = 8'd30,
   parameter logic [7:0] THR_LO      = 8'd25,
   parameter int         ERR_LIMIT   = 3,
   parameter int         TIMEOUT_CYC = 12_000_000
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic       byte_ok,
   input  logic [7:0] byte_data,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       alarm,
   output logic       fault,
   output logic       timeout,
   output logic [7:0] err_cnt,
   output logic [1:0] led
);
   localparam int N  = 2 ** AVG_LOG2;
   localparam int SW = 8 + AVG_LOG2;
   localparam int CW = $clog2(ERR_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(N - 1);
   localparam logic [CW-1:0]       ERR_MAX   = CW'(ERR_LIMIT);
   localparam logic [TW-1:0]       TO_MAX    = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {FILL, RUN, FAULT} state_e;

   state_e              state_q, state_d;
   logic [7:0]          win_q [N];
   logic [7:0]          win_d [N];
   logic [SW-1:0]       sum_q, sum_d;
   logic [AVG_LOG2-1:0] ptr_q, ptr_d;
   logic [AVG_LOG2-1:0] fill_q, fill_d;
   logic [CW-1:0]       consec_q, consec_d;
   logic [TW-1:0]       to_q, to_d;
   logic [7:0]          avg_q, avg_d;
   logic                avg_valid_q, avg_valid_d;
   logic                alarm_q, alarm_d;
   logic                timeout_q, timeout_d;
   logic [7:0]          err_q, err_d;
   logic                good, bad, err_hit;

   assign good     = byte_valid & byte_ok;
   assign bad      = byte_valid & ~byte_ok;
   assign consec_d = bad ? ((consec_q == ERR_MAX) ? consec_q : consec_q + 1'b1) : good ? '0 : consec_q;
   assign err_hit  = bad && (consec_d == ERR_MAX);

   always_ff @(posedge clk_in) begin
      if (!rst) begin
         state_q     <= FILL;
         for (int i = 0; i < N; i++) win_q[i] <= '0;
         sum_q       <= '0;
         ptr_q       <= '0;
         fill_q      <= '0;
         consec_q    <= '0;
         to_q        <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         sum_q       <= sum_d;
         ptr_q       <= ptr_d;
         fill_q      <= fill_d;
         consec_q    <= consec_d;
         to_q        <= to_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         alarm_q     <= alarm_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == FAULT) state_d = good ? FILL : FAULT;
      else if (err_hit) state_d = FAULT;
      else if (good && state_q == FILL && fill_q == FILL_LAST) state_d = RUN;
   end

   always_comb begin
      win_d       = win_q;
      sum_d       = sum_q;
      ptr_d       = ptr_q;
      fill_d      = fill_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      if (good && state_q == FAULT) begin
         // Recovery restarts the window with this byte as its only sample
         for (int i = 0; i < N; i++) win_d[i] = '0;
         win_d[0] = byte_data;
         sum_d    = SW'(byte_data);
         ptr_d    = AVG_LOG2'(1);
         fill_d   = AVG_LOG2'(1);
      end else if (good) begin
         win_d[ptr_q] = byte_data;
         sum_d        = sum_q - SW'(win_q[ptr_q]) + SW'(byte_data);
         ptr_d        = ptr_q + 1'b1;
         fill_d       = fill_q + 1'b1;
         if (state_d == RUN) begin
            avg_d       = 8'(sum_d >> AVG_LOG2);
            avg_valid_d = 1'b1;
         end
      end
      // Alarm judges the average published on the previous cycle
      alarm_d   = (state_d == FAULT) ? 1'b0 :
                  !avg_valid_q ? alarm_q :
                  (avg_q > THR_HI) ? 1'b1 :
                  (avg_q < THR_LO) ? 1'b0 : alarm_q;
      err_d     = (bad && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
      to_d      = good ? '0 : (to_q == TO_MAX) ? to_q : to_q + 1'b1;
      timeout_d = (to_d == TO_MAX);
   end

   always_comb begin
      avg_out   = avg_q;
      avg_valid = avg_valid_q;
      alarm     = alarm_q;
      fault     = (state_q == FAULT);
      timeout   = timeout_q;
      err_cnt   = err_q;
      led       = {~(fault | timeout_q), ~alarm_q};
   end
endmodule

// File: tb/tb_spi_sample_monitor.sv
// tb_spi_sample_monitor: directed self-checking bench for spi_sample_monitor.
module tb_spi_sample_monitor;
   logic       clk_in = 1'b0;
   logic       rst = 1'b0;
   logic       byte_valid = 1'b0;
   logic       byte_ok = 1'b0;
   logic [7:0] byte_data = '0;
   logic [7:0] avg_out;
   logic       avg_valid;
   logic       alarm;
   logic       fault;
   logic       timeout;
   logic [7:0] err_cnt;
   logic [1:0] led;
   int         n_vec = 0;
   int         n_err = 0;

   // hysteresis walk: sample, expected average, expected alarm after update
   logic [7:0] hd [15] = '{8'd40, 8'd50, 8'd28, 8'd28, 8'd28, 8'd28, 8'd24, 8'd24,
                           8'd24, 8'd24, 8'd30, 8'd30, 8'd30, 8'd30, 8'd40};
   logic [7:0] ha [15] = '{8'd25, 8'd35, 8'd37, 8'd36, 8'd33, 8'd28, 8'd27, 8'd26,
                           8'd25, 8'd24, 8'd25, 8'd27, 8'd28, 8'd30, 8'd32};
   logic       hl [15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   spi_sample_monitor #(.TIMEOUT_CYC(100)) dut (
      .clk_in(clk_in), .rst(rst), .byte_valid(byte_valid), .byte_ok(byte_ok),
      .byte_data(byte_data), .avg_out(avg_out), .avg_valid(avg_valid), .alarm(alarm),
      .fault(fault), .timeout(timeout), .err_cnt(err_cnt), .led(led)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the sampling posedge
   task automatic send(input logic ok, input logic [7:0] d);
      byte_valid = 1'b1;
      byte_ok = ok;
      byte_data = d;
      @(negedge clk_in);
      byte_valid = 1'b0;
   endtask

   task automatic send_chk(input logic [7:0] d, input logic [7:0] avg, input logic al0, input logic al1);
      send(1'b1, d);
      check("avg_valid", avg_valid, 1);
      check("avg_out", avg_out, avg);
      check("alarm_before", alarm, al0);
      @(negedge clk_in);
      check("avg_valid_pulse", avg_valid, 0);
      check("alarm_after", alarm, al1);
   endtask

   initial begin
      logic prev;
      repeat (2) @(negedge clk_in);
      check("rst_avg", avg_out, 0);
      check("rst_avg_valid", avg_valid, 0);
      check("rst_alarm", alarm, 0);
      check("rst_fault", fault, 0);
      check("rst_timeout", timeout, 0);
      check("rst_err", err_cnt, 0);
      check("rst_led", led, 2'b11);
      rst = 1'b1;
      @(negedge clk_in);
      send(1'b1, 8'd10);
      send(1'b1, 8'd20);
      rst = 1'b0;
      @(negedge clk_in);
      rst = 1'b1;
      check("midrst_avg", avg_out, 0);
      check("midrst_led", led, 2'b11);
      send(1'b1, 8'd10);
      check("fill1_valid", avg_valid, 0);
      send(1'b1, 8'd20);
      check("fill2_valid", avg_valid, 0);
      send(1'b1, 8'd30);
      check("fill3_valid", avg_valid, 0);
      check("fill3_avg", avg_out, 0);
      prev = 1'b0;
      for (int i = 0; i < 15; i++) begin
         send_chk(hd[i], ha[i], prev, hl[i]);
         prev = hl[i];
      end
      send(1'b0, 8'd0);
      check("bad1_fault", fault, 0);
      send(1'b0, 8'd0);
      check("bad2_fault", fault, 0);
      check("bad2_err", err_cnt, 2);
      send(1'b0, 8'd0);
      check("bad3_err", err_cnt, 3);
      check("bad3_fault", fault, 1);
      check("bad3_alarm", alarm, 0);
      check("bad3_led", led, 2'b01);
      check("bad3_avg", avg_out, 32);
      send(1'b1, 8'd8);
      check("recover_fault", fault, 0);
      check("recover_valid", avg_valid, 0);
      send(1'b1, 8'd12);
      check("refill2_valid", avg_valid, 0);
      send(1'b1, 8'd16);
      check("refill3_valid", avg_valid, 0);
      send_chk(8'd20, 8'd14, 1'b0, 1'b0);
      send(1'b0, 8'd0);
      send(1'b0, 8'd0);
      send(1'b1, 8'd50);
      send(1'b0, 8'd0);
      send(1'b0, 8'd0);
      check("nonconsec_fault", fault, 0);
      check("nonconsec_err", err_cnt, 7);
      repeat (247) send(1'b0, 8'd0);
      check("err_254", err_cnt, 254);
      check("burst_fault", fault, 1);
      send(1'b0, 8'd0);
      check("err_255", err_cnt, 255);
      send(1'b0, 8'd0);
      check("err_sat", err_cnt, 255);
      check("idle_timeout", timeout, 1);
      check("idle_led", led, 2'b01);
      send(1'b1, 8'd5);
      check("good_fault", fault, 0);
      check("good_timeout", timeout, 0);
      check("good_led", led, 2'b11);
      repeat (98) @(negedge clk_in);
      check("to_98", timeout, 0);
      @(negedge clk_in);
      check("to_99", timeout, 1);
      check("to_led", led, 2'b01);
      send(1'b1, 8'd5);
      check("to_clear", timeout, 0);
      repeat (97) @(negedge clk_in);
      send(1'b1, 8'd5);
      check("to_race", timeout, 0);
      @(negedge clk_in);
      check("to_race_after", timeout, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
